// File: rtl/trdb_packet_scheduler_if.sv
// Handshake and qualifier bundle between the retirement stage, the packet
// scheduler and the packet emitter.
interface trdb_packet_scheduler_if #(
  parameter int BMAP_LEN = 31
);
  localparam int CNT_W = $clog2(BMAP_LEN + 1);

  logic                trace_enable_i;
  logic                iretire_i;
  logic                exception_i;
  logic                priv_change_i;
  logic                updiscon_i;
  logic                branch_i;
  logic                branch_taken_i;
  logic                emitter_ready_i;

  logic                packet_valid_o;
  logic [1:0]          packet_format_o;
  logic [1:0]          packet_subformat_o;
  logic [CNT_W-1:0]    branches_o;
  logic [BMAP_LEN-1:0] branch_map_o;
  logic [1:0]          qual_status_o;
  logic                resync_timeout_o;
  logic                overflow_o;

  // retirement side / emitter side that feeds and drains the scheduler
  modport master (
    output trace_enable_i, iretire_i, exception_i, priv_change_i, updiscon_i,
           branch_i, branch_taken_i, emitter_ready_i,
    input  packet_valid_o, packet_format_o, packet_subformat_o, branches_o,
           branch_map_o, qual_status_o, resync_timeout_o, overflow_o
  );

  // the scheduler itself
  modport slave (
    input  trace_enable_i, iretire_i, exception_i, priv_change_i, updiscon_i,
           branch_i, branch_taken_i, emitter_ready_i,
    output packet_valid_o, packet_format_o, packet_subformat_o, branches_o,
           branch_map_o, qual_status_o, resync_timeout_o, overflow_o
  );
endinterface

// File: rtl/trdb_packet_scheduler.sv
// Trace packet scheduler: tracks the branch map, branch count and resync
// timer, decides which packet the emitter must produce, and holds each
// decision in a one-entry register behind a valid/ready handshake.
//
// state | meaning
// IDLE  | tracing off, waiting for trace_enable_i
// START | next retirement produces F_SYNC/SF_START
// RUN   | normal packet decisions per retired instruction
// STOP  | issue F_SYNC/SF_SUPPORT, wait for its acceptance, then IDLE
module trdb_packet_scheduler #(
  parameter int RESYNC_MAX = 255,
  parameter int BMAP_LEN   = 31
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  trdb_packet_scheduler_if.slave  bus
);
  localparam int CNT_W = $clog2(BMAP_LEN + 1);
  localparam int TMR_W = $clog2(RESYNC_MAX + 1);

  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(RESYNC_MAX);
  localparam logic [TMR_W-1:0] TMR_PRE  = TMR_W'(RESYNC_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BMAP_LEN);

  localparam logic [1:0] F_DIFF_DELTA = 2'd1;
  localparam logic [1:0] F_ADDR_ONLY  = 2'd2;
  localparam logic [1:0] F_SYNC       = 2'd3;
  localparam logic [1:0] SF_START     = 2'd0;
  localparam logic [1:0] SF_TRAP      = 2'd1;
  localparam logic [1:0] SF_SUPPORT   = 2'd3;
  localparam logic [1:0] Q_NO_CHANGE  = 2'd0;
  localparam logic [1:0] Q_TRACE_LOST = 2'd2;
  localparam logic [1:0] Q_ENDED_NTR  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_STOP} state_e;

  state_e              state_q, state_d;
  logic [BMAP_LEN-1:0] map_q, map_d, map_upd;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_upd;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                pend_q, pend_d;
  logic                sticky_q, sticky_d;
  logic                stop_sent_q, stop_sent_d;

  logic                hold_valid_q;
  logic [1:0]          hold_fmt_q, hold_sub_q, hold_qual_q;
  logic [CNT_W-1:0]    hold_cnt_q;
  logic [BMAP_LEN-1:0] hold_map_q;
  logic                ovf_q;

  logic                demand, take, drop, free, accept, rec;
  logic [1:0]          dec_fmt, dec_sub, dec_qual;
  logic [BMAP_LEN-1:0] dec_map;
  logic [CNT_W-1:0]    dec_cnt;

  assign accept = hold_valid_q && bus.emitter_ready_i;
  assign free   = !hold_valid_q || bus.emitter_ready_i;
  assign rec    = bus.iretire_i && bus.branch_i && bus.trace_enable_i &&
                  ((state_q == S_START) || (state_q == S_RUN));

  // live map and count including the branch retiring this cycle
  always_comb begin
    map_upd = map_q;
    cnt_upd = cnt_q;
    if (rec) begin
      map_upd[cnt_q] = ~bus.branch_taken_i;
      cnt_upd        = cnt_q + CNT_W'(1);
    end
  end

  // next state, packet decision, overflow and timer update
  always_comb begin
    state_d     = state_q;
    map_d       = map_q;
    cnt_d       = cnt_q;
    tmr_d       = tmr_q;
    pend_d      = pend_q;
    sticky_d    = sticky_q;
    stop_sent_d = stop_sent_q;
    demand      = 1'b0;
    dec_fmt     = F_SYNC;
    dec_sub     = SF_START;
    dec_qual    = Q_NO_CHANGE;
    dec_map     = map_upd;
    dec_cnt     = cnt_upd;
    unique case (state_q)
      S_IDLE: begin
        if (bus.trace_enable_i) state_d = S_START;
      end
      S_START: begin
        if (!bus.trace_enable_i) begin
          state_d = S_IDLE;
        end else if (bus.iretire_i) begin
          demand  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (tmr_q != TMR_MAX) tmr_d = tmr_q + TMR_W'(1);
        if (tmr_q == TMR_PRE) pend_d = 1'b1;
        if (!bus.trace_enable_i) begin
          // disable wins over a retirement in the same cycle
          state_d     = S_STOP;
          stop_sent_d = 1'b0;
          map_d       = '0;
          cnt_d       = '0;
        end else if (bus.iretire_i) begin
          demand = 1'b1;
          if (bus.exception_i) begin
            dec_sub = SF_TRAP;
          end else if (bus.priv_change_i || pend_q) begin
            dec_sub = SF_START;
          end else if (bus.updiscon_i) begin
            dec_fmt = (cnt_upd != '0) ? F_DIFF_DELTA : F_ADDR_ONLY;
          end else if (cnt_upd == CNT_FULL) begin
            dec_fmt = F_DIFF_DELTA;
          end else begin
            demand = 1'b0;
            map_d  = map_upd;
            cnt_d  = cnt_upd;
          end
        end
      end
      S_STOP: begin
        // waiting for a free holding register here is not an overflow
        if (!stop_sent_q) begin
          if (free) begin
            demand      = 1'b1;
            dec_sub     = SF_SUPPORT;
            dec_qual    = sticky_q ? Q_TRACE_LOST : Q_ENDED_NTR;
            dec_map     = '0;
            dec_cnt     = '0;
            sticky_d    = 1'b0;
            stop_sent_d = 1'b1;
          end
        end else if (accept) begin
          state_d     = S_IDLE;
          stop_sent_d = 1'b0;
        end
      end
    endcase
    take = demand && free;
    drop = demand && !free;
    if (drop) begin
      sticky_d = 1'b1;
      map_d    = '0;
      cnt_d    = '0;
      state_d  = S_START;
    end
    if (take) begin
      map_d = '0;
      cnt_d = '0;
      if (dec_fmt == F_SYNC) begin
        tmr_d  = '0;
        pend_d = 1'b0;
      end
    end
  end

  // FSM state, live branch map, resync timer and sticky flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      map_q       <= '0;
      cnt_q       <= '0;
      tmr_q       <= '0;
      pend_q      <= 1'b0;
      sticky_q    <= 1'b0;
      stop_sent_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      map_q       <= map_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      pend_q      <= pend_d;
      sticky_q    <= sticky_d;
      stop_sent_q <= stop_sent_d;
    end
  end

  // one-entry holding register presented to the emitter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_valid_q <= 1'b0;
      hold_fmt_q   <= '0;
      hold_sub_q   <= '0;
      hold_qual_q  <= '0;
      hold_cnt_q   <= '0;
      hold_map_q   <= '0;
      ovf_q        <= 1'b0;
    end else begin
      ovf_q <= drop;
      if (take) begin
        hold_valid_q <= 1'b1;
        hold_fmt_q   <= dec_fmt;
        hold_sub_q   <= dec_sub;
        hold_qual_q  <= dec_qual;
        hold_cnt_q   <= dec_cnt;
        hold_map_q   <= dec_map;
      end else if (accept) begin
        hold_valid_q <= 1'b0;
      end
    end
  end

  assign bus.packet_valid_o     = hold_valid_q;
  assign bus.packet_format_o    = hold_fmt_q;
  assign bus.packet_subformat_o = hold_sub_q;
  assign bus.branches_o         = hold_cnt_q;
  assign bus.branch_map_o       = hold_map_q;
  assign bus.qual_status_o      = hold_qual_q;
  assign bus.resync_timeout_o   = pend_q;
  assign bus.overflow_o         = ovf_q;
endmodule
